// File: rtl/alarm_bank.sv
`default_nettype none
// ============================================================================
//  Module      : alarm_bank
//  Description : Multi-channel BCD alarm clock controller. Each channel raises
//                a ring on the rising edge of its time match. The ring can be
//                stopped, can time out, or can be snoozed and then re-ring.
//                Optional feature macro: ALARM_SNOOZE_EN (snooze support).
//  Revision    : 1.0 - initial release
// ============================================================================
module alarm_bank #(
    parameter int NUM_ALARMS = 4,
    parameter int LED_W      = 16,
    parameter int RING_SEC   = 60,
    parameter int SNOOZE_SEC = 300
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    tick_1hz,
    input  logic [15:0]             time_bcd,
    input  logic [16*NUM_ALARMS-1:0] alarm_bcd,
    input  logic [NUM_ALARMS-1:0]   alarm_en,
    input  logic                    stop_btn,
    input  logic                    snooze_btn,
    output logic [LED_W-1:0]        led,
    output logic                    ringing,
    output logic [3:0]              active_ch
);

    localparam logic [15:0]      c_ring_load = 16'(RING_SEC);
    localparam logic [LED_W-1:0] c_led_init  = {(LED_W/2){2'b10}};

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_RINGING = 2'b01,
        ST_SNOOZE  = 2'b10
    } state_t;

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [15:0]             r_ring_cnt;
    logic [15:0]             w_ring_cnt_nxt;
    logic [LED_W-1:0]        r_led;
    logic [LED_W-1:0]        w_led_nxt;
    logic                    r_ringing;
    logic [3:0]              r_active_ch;
    logic [3:0]              w_active_ch_nxt;
    logic [NUM_ALARMS-1:0]   r_match_prev;
    logic                    r_armed;
    logic                    r_stop_prev;

    logic [NUM_ALARMS-1:0]   w_match;
    logic [NUM_ALARMS-1:0]   w_rise;
    logic                    w_trig;
    logic [3:0]              w_trig_ch;
    logic                    w_stop_edge;
    logic [15:0]             w_en_ext;
    logic                    w_ch_enabled;

`ifdef ALARM_SNOOZE_EN
    localparam logic [15:0]  c_snz_load = 16'(SNOOZE_SEC);
    logic [15:0]             r_snz_cnt;
    logic [15:0]             w_snz_cnt_nxt;
    logic                    r_snz_prev;
    logic                    w_snz_edge;
    assign w_snz_edge = snooze_btn & ~r_snz_prev;
`else
    // Button is still present on the port list but has no function here.
    logic                    w_unused_snooze;
    assign w_unused_snooze = snooze_btn;
`endif

    // Per-channel full 16-bit time compare, gated by the channel enable.
    for (genvar g = 0; g < NUM_ALARMS; g++) begin : g_ch
        assign w_match[g] = alarm_en[g] & (time_bcd == alarm_bcd[16*g +: 16]);
    end

    // Rising-edge detection; suppressed on the first clock after reset so that
    // a channel already matching at release does not fire.
    assign w_rise       = w_match & ~r_match_prev & {NUM_ALARMS{r_armed}};
    assign w_stop_edge  = stop_btn & ~r_stop_prev;
    assign w_en_ext     = 16'(alarm_en);
    assign w_ch_enabled = w_en_ext[r_active_ch];

    // Lowest-index rising channel wins; scanning downward leaves the lowest.
    always_comb begin
        w_trig    = 1'b0;
        w_trig_ch = 4'd0;
        for (int i = NUM_ALARMS - 1; i >= 0; i--) begin
            if (w_rise[i]) begin
                w_trig    = 1'b1;
                w_trig_ch = 4'(i);
            end
        end
    end

    // Next-state, counter and output pattern computation.
    always_comb begin
        w_state_nxt     = r_state;
        w_ring_cnt_nxt  = r_ring_cnt;
        w_led_nxt       = r_led;
        w_active_ch_nxt = r_active_ch;
`ifdef ALARM_SNOOZE_EN
        w_snz_cnt_nxt   = r_snz_cnt;
`endif
        case (r_state)
            ST_IDLE: begin
                w_led_nxt = '0;
                // A tick in the same cycle as the trigger is not applied.
                if (w_trig) begin
                    w_state_nxt     = ST_RINGING;
                    w_active_ch_nxt = w_trig_ch;
                    w_ring_cnt_nxt  = c_ring_load;
                    w_led_nxt       = c_led_init;
                end
            end
            ST_RINGING: begin
                if (!w_ch_enabled || w_stop_edge) begin
                    w_state_nxt = ST_IDLE;
                    w_led_nxt   = '0;
                end
`ifdef ALARM_SNOOZE_EN
                else if (w_snz_edge) begin
                    w_state_nxt   = ST_SNOOZE;
                    w_snz_cnt_nxt = c_snz_load;
                    w_led_nxt     = '0;
                end
`endif
                else if (tick_1hz) begin
                    if (r_ring_cnt <= 16'd1) begin
                        w_state_nxt    = ST_IDLE;
                        w_ring_cnt_nxt = 16'd0;
                        w_led_nxt      = '0;
                    end else begin
                        w_ring_cnt_nxt = r_ring_cnt - 16'd1;
                        w_led_nxt      = ~r_led;
                    end
                end
            end
`ifdef ALARM_SNOOZE_EN
            ST_SNOOZE: begin
                w_led_nxt = '0;
                if (!w_ch_enabled || w_stop_edge) begin
                    w_state_nxt = ST_IDLE;
                end else if (tick_1hz) begin
                    if (r_snz_cnt <= 16'd1) begin
                        w_state_nxt    = ST_RINGING;
                        w_snz_cnt_nxt  = 16'd0;
                        w_ring_cnt_nxt = c_ring_load;
                        w_led_nxt      = c_led_init;
                    end else begin
                        w_snz_cnt_nxt = r_snz_cnt - 16'd1;
                    end
                end
            end
`endif
            default: begin
                w_state_nxt = ST_IDLE;
                w_led_nxt   = '0;
            end
        endcase
    end

    // State, counters, edge-detect history and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_ring_cnt   <= 16'd0;
            r_led        <= '0;
            r_ringing    <= 1'b0;
            r_active_ch  <= 4'd0;
            r_match_prev <= '0;
            r_armed      <= 1'b0;
            r_stop_prev  <= 1'b0;
`ifdef ALARM_SNOOZE_EN
            r_snz_cnt    <= 16'd0;
            r_snz_prev   <= 1'b0;
`endif
        end else begin
            r_state      <= w_state_nxt;
            r_ring_cnt   <= w_ring_cnt_nxt;
            r_led        <= w_led_nxt;
            r_ringing    <= (w_state_nxt == ST_RINGING);
            r_active_ch  <= w_active_ch_nxt;
            r_match_prev <= w_match;
            r_armed      <= 1'b1;
            r_stop_prev  <= stop_btn;
`ifdef ALARM_SNOOZE_EN
            r_snz_cnt    <= w_snz_cnt_nxt;
            r_snz_prev   <= snooze_btn;
`endif
        end
    end

    assign led       = r_led;
    assign ringing   = r_ringing;
    assign active_ch = r_active_ch;

endmodule
`default_nettype wire

// File: tb/tb_alarm_bank.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alarm_bank
//  Description : Self-checking bench for alarm_bank: directed scenarios then
//                random stimulus, all compared against a behavioural model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_alarm_bank;

    localparam int NA  = 4;
    localparam int RS  = 3;
    localparam int SS  = 2;
`ifdef ALARM_SNOOZE_EN
    localparam bit SNZ = 1'b1;
`else
    localparam bit SNZ = 1'b0;
`endif

    logic           clk = 1'b0;
    logic           rst_n;
    logic           tick_1hz;
    logic [15:0]    time_bcd;
    logic [16*NA-1:0] alarm_bcd;
    logic [NA-1:0]  alarm_en;
    logic           stop_btn;
    logic           snooze_btn;
    logic [15:0]    led;
    logic           ringing;
    logic [3:0]     active_ch;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: mode 0 idle, 1 ringing, 2 snoozing.
    int         m_mode;
    int         m_ch;
    int         m_left;
    bit         m_odd;
    logic [NA-1:0] m_prev_match;
    bit         m_prev_stop;
    bit         m_prev_snz;
    bit         m_armed;

    alarm_bank #(
        .NUM_ALARMS (NA),
        .LED_W      (16),
        .RING_SEC   (RS),
        .SNOOZE_SEC (SS)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .tick_1hz   (tick_1hz),
        .time_bcd   (time_bcd),
        .alarm_bcd  (alarm_bcd),
        .alarm_en   (alarm_en),
        .stop_btn   (stop_btn),
        .snooze_btn (snooze_btn),
        .led        (led),
        .ringing    (ringing),
        .active_ch  (active_ch)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_mode       = 0;
        m_ch         = 0;
        m_left       = 0;
        m_odd        = 1'b0;
        m_prev_match = '0;
        m_prev_stop  = 1'b0;
        m_prev_snz   = 1'b0;
        m_armed      = 1'b0;
    endtask

    // Apply the alarm rules to the inputs present just before a clock edge.
    task automatic model_edge();
        int            trig;
        bit            stop_e;
        bit            snz_e;
        logic [NA-1:0] nm;
        trig   = -1;
        stop_e = stop_btn && !m_prev_stop;
        snz_e  = snooze_btn && !m_prev_snz;
        for (int c = NA - 1; c >= 0; c--) begin
            nm[c] = alarm_en[c] && (time_bcd == alarm_bcd[16*c +: 16]);
            if (nm[c] && !m_prev_match[c] && m_armed) trig = c;
        end
        case (m_mode)
            0: if (trig >= 0) begin
                m_mode = 1; m_ch = trig; m_left = RS; m_odd = 1'b0;
            end
            1: begin
                if (!alarm_en[m_ch] || stop_e) m_mode = 0;
                else if (SNZ && snz_e) begin m_mode = 2; m_left = SS; end
                else if (tick_1hz) begin
                    m_left = m_left - 1;
                    m_odd  = !m_odd;
                    if (m_left == 0) m_mode = 0;
                end
            end
            default: begin
                if (!alarm_en[m_ch] || stop_e) m_mode = 0;
                else if (tick_1hz) begin
                    m_left = m_left - 1;
                    if (m_left == 0) begin
                        m_mode = 1; m_left = RS; m_odd = 1'b0;
                    end
                end
            end
        endcase
        m_prev_match = nm;
        m_prev_stop  = stop_btn;
        m_prev_snz   = snooze_btn;
        m_armed      = 1'b1;
    endtask

    task automatic check_model();
        logic [15:0] el;
        el = (m_mode == 1) ? (m_odd ? 16'h5555 : 16'hAAAA) : 16'h0000;
        chk("model_ringing",   16'(ringing),   16'(m_mode == 1));
        chk("model_active_ch", 16'(active_ch), 16'(m_ch));
        chk("model_led",       led,            el);
    endtask

    task automatic step(input bit tk);
        tick_1hz = tk;
        model_edge();
        @(posedge clk);
        #1;
        tick_1hz = 1'b0;
        check_model();
    endtask

    initial begin
        logic [15:0] tv [5];
        tv = '{16'h0600, 16'h0559, 16'h0730, 16'h0729, 16'h2359};

        rst_n      = 1'b0;
        tick_1hz   = 1'b0;
        time_bcd   = 16'h0000;
        alarm_bcd  = {16'h2359, 16'h0600, 16'h0730, 16'h0600};
        alarm_en   = 4'b0000;
        stop_btn   = 1'b0;
        snooze_btn = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("reset_ringing",   16'(ringing),   16'h0);
        chk("reset_led",       led,            16'h0);
        chk("reset_active_ch", 16'(active_ch), 16'h0);
        #2 rst_n = 1'b1;

        // Channel 1 at 07:30
        alarm_en = 4'b0010;
        time_bcd = 16'h0729;
        step(0); step(0);
        time_bcd = 16'h0730;
        step(0);
        chk("ring_start_ringing", 16'(ringing),   16'h1);
        chk("ring_start_ch",      16'(active_ch), 16'h1);
        chk("ring_start_led",     led,            16'hAAAA);
        step(1);
        chk("ring_tick_led", led, 16'h5555);

        // Stop held for five clocks, then a full minute of ticks at 07:30
        stop_btn = 1'b1;
        repeat (5) step(0);
        stop_btn = 1'b0;
        chk("stop_ringing", 16'(ringing), 16'h0);
        chk("stop_led",     led,          16'h0);
        repeat (60) begin step(1); step(0); end
        chk("no_retrigger", 16'(ringing), 16'h0);

        // Auto-silence on the third tick
        time_bcd = 16'h0731; step(0);
        time_bcd = 16'h0730; step(0);
        chk("timeout_start", 16'(ringing), 16'h1);
        step(1); step(0); step(1);
        chk("timeout_two_ticks", 16'(ringing), 16'h1);
        step(1);
        chk("timeout_ringing", 16'(ringing), 16'h0);
        chk("timeout_led",     led,          16'h0);

        // Snooze (or ignored snooze when the feature is absent)
        time_bcd = 16'h0731; step(0);
        time_bcd = 16'h0730; step(0);
        snooze_btn = 1'b1;
        step(0);
        snooze_btn = 1'b0;
        chk("snooze_ringing", 16'(ringing), SNZ ? 16'h0 : 16'h1);
        chk("snooze_led",     led,          SNZ ? 16'h0 : 16'hAAAA);
        step(1); step(0); step(1);
        chk("rering_ringing", 16'(ringing), 16'h1);
        chk("rering_led",     led,          16'hAAAA);
        stop_btn = 1'b1; step(0);
        stop_btn = 1'b0; step(0);
        chk("snooze_stop", 16'(ringing), 16'h0);

        // Channels 0 and 2 both at 06:00
        alarm_en = 4'b0101;
        time_bcd = 16'h0559; step(0);
        time_bcd = 16'h0600; step(0);
        chk("prio_ch",      16'(active_ch), 16'h0);
        chk("prio_ringing", 16'(ringing),   16'h1);
        stop_btn = 1'b1; snooze_btn = 1'b1;
        step(0);
        stop_btn = 1'b0; snooze_btn = 1'b0;
        chk("stop_wins", 16'(ringing), 16'h0);
        step(0);
        time_bcd = 16'h0559; step(0);
        time_bcd = 16'h0600; step(0);
        chk("en_clear_pre", 16'(ringing), 16'h1);
        alarm_en = 4'b0100;
        step(0);
        chk("en_clear", 16'(ringing), 16'h0);
        time_bcd = 16'h0559; step(0);
        alarm_en = 4'b0101; step(0);

        // Asynchronous reset in the middle of a ring
        time_bcd = 16'h0600; step(0);
        chk("areset_pre", 16'(ringing), 16'h1);
        #2 rst_n = 1'b0;
        #1;
        chk("areset_ringing", 16'(ringing),   16'h0);
        chk("areset_led",     led,            16'h0);
        chk("areset_ch",      16'(active_ch), 16'h0);
        model_reset();
        @(posedge clk);
        #3 rst_n = 1'b1;
        repeat (3) begin step(0); step(1); end
        chk("no_ring_after_reset", 16'(ringing), 16'h0);

        // Random stimulus against the model
        for (int n = 0; n < 800; n++) begin
            if ($urandom_range(0, 3) == 0) time_bcd = tv[$urandom_range(0, 4)];
            if ($urandom_range(0, 39) == 0) alarm_en = 4'($urandom_range(0, 15));
            stop_btn   = ($urandom_range(0, 11) == 0);
            snooze_btn = ($urandom_range(0, 9) == 0);
            step($urandom_range(0, 2) == 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/alarm_bank.md
ALARM_BANK -- requirements
Module: alarm_bank

Interface
REQ-001 Parameter NUM_ALARMS, default 4: number of independent alarm channels (1..16).
REQ-002 Parameter LED_W, default 16: LED output width (even, >= 2).
REQ-003 Parameter RING_SEC, default 60: ticks a ring lasts before auto-silence (1..65535).
REQ-004 Parameter SNOOZE_SEC, default 300: ticks spent in snooze before re-ring (1..65535).
REQ-005 clk  input  1  single system clock; all state on rising edge.
REQ-006 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-007 tick_1hz  input  1  one-clk-wide pulse, once per second, clk-synchronous.
REQ-008 time_bcd  input  16  current time, four BCD digits {HH tens, HH units, MM tens, MM units}.
REQ-009 alarm_bcd  input  16*NUM_ALARMS  alarm time per channel, channel i at bits [16i+15:16i].
REQ-010 alarm_en  input  NUM_ALARMS  per-channel enable (switches, clk-synchronous).
REQ-011 stop_btn  input  1  stop request, level, clk-synchronous.
REQ-012 snooze_btn  input  1  snooze request, level, clk-synchronous.
REQ-013 led  output  LED_W  registered ring pattern.
REQ-014 ringing  output  1  registered; high while state is RINGING.
REQ-015 active_ch  output  4  registered index of the channel that caused the current ring/snooze.

Function
REQ-016 Channel i match = alarm_en[i] AND time_bcd == alarm_bcd channel i; comparison combinational, all 16 bits.
REQ-017 Trigger = rising edge of a channel's match (registered previous match per channel); a match held for a whole minute triggers once only.
REQ-018 Multiple channels triggering in the same cycle: lowest index wins; others discarded.
REQ-019 States: IDLE, RINGING, SNOOZE; 2-bit encoding, any unused code returns to IDLE next cycle.
REQ-020 IDLE -> RINGING on trigger; active_ch loaded; ring counter loaded with RING_SEC.
REQ-021 stop_btn and snooze_btn act on their rising edge only (registered previous level); held levels have no further effect.
REQ-022 RINGING -> IDLE on stop edge, or when ring counter reaches 0 (decrement by 1 per tick_1hz).
REQ-023 RINGING -> SNOOZE on snooze edge; snooze counter loaded with SNOOZE_SEC.
REQ-024 SNOOZE -> RINGING when snooze counter reaches 0 (decrement per tick); ring counter reloaded with RING_SEC.
REQ-025 SNOOZE -> IDLE on stop edge.
REQ-026 Stop and snooze edges in the same cycle: stop wins.
REQ-027 Clearing alarm_en[active_ch] while RINGING or SNOOZE forces IDLE next edge, priority over all other events.
REQ-028 Triggers arriving while RINGING or SNOOZE are discarded; stop/snooze edges in IDLE are ignored.
REQ-029 Trigger and tick in the same IDLE cycle: counter loads RING_SEC, tick not applied.
REQ-030 Counters are 16-bit, never wrap below 0.
REQ-031 led = {LED_W/2{2'b10}} on entry to RINGING; inverts on every tick_1hz while RINGING; all zero in IDLE and SNOOZE.
REQ-032 led, ringing, active_ch update on the same clk edge as the state change (zero-cycle skew between them); trigger-to-ringing latency one clk.

Reset
REQ-033 rst_n low: state IDLE, led = 0, ringing = 0, active_ch = 0, both counters 0, all edge-detect registers 0, effective immediately without clk.
REQ-034 Reset mid-ring or mid-snooze abandons the event; no ring resumes after release unless a new match edge occurs.
REQ-035 Channels already matching at reset release do not trigger (previous-match registers load current match on the first clk after release).

Configuration
REQ-036 Macro ALARM_SNOOZE_EN defined: snooze behaviour per REQ-023/024/025.
REQ-037 ALARM_SNOOZE_EN undefined: snooze_btn port kept but ignored, SNOOZE state and snooze counter not synthesised, RINGING exits only via stop, timeout or REQ-027.

Verification
REQ-038 Channel 1 = 0730, enabled; time_bcd 0729 -> 0730 -> ringing=1, active_ch=1, led=16'hAAAA one clk later; next tick led=16'h5555.
REQ-039 Ringing, stop_btn held 5 clk -> IDLE, led=0; hold time at 0730 for 60 ticks -> no re-trigger.
REQ-040 Ringing, no input, RING_SEC=3 -> ringing drops on the 3rd tick, led=0.
REQ-041 SNOOZE_SEC=2, ALARM_SNOOZE_EN defined: snooze edge -> led=0, ringing=0; after 2 ticks ringing=1, led=16'hAAAA; same stimulus with macro undefined -> ringing stays 1.
REQ-042 Channels 0 and 2 both 0600 -> active_ch=0; stop and snooze same cycle -> IDLE; clear alarm_en[0] during ring -> IDLE next clk.
REQ-043 rst_n pulsed low mid-ring with time still 0600 -> outputs 0 asynchronously; no ring after release.
